fm_packet_tx: RTL
=================

Name: fm_packet_tx

Overview:
Transmit side of the FM-to-Extender memory-packet interface.
- Accepts a genome byte stream, one byte (two bases) per cycle.
- Packs the bytes into FM_EXTENDER_BYTES_READ_COUNT-byte packets (EXTENDER_MEM_LEN bits) and hands them to the Extender over a valid/ready handshake.
- Uses ping-pong buffering with FM_BUFFER_COUNT = 2, so filling one packet overlaps with draining the other.

Parameters:
- BYTES_PER_PKT, default FM_EXTENDER_BYTES_READ_COUNT (16): bytes per packet.
- BYTE_W, default GENOME_BTYE (8): bits per genome byte.
- IDX_W, default 16: width of the packet sequence index.
- Derived localparams: PKT_W = BYTES_PER_PKT*BYTE_W (128); CNT_W = $clog2(BYTES_PER_PKT+1) (5).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_byte  in  BYTE_W  genome byte; bits [3:0] hold the earlier base, [7:4] the later base
- in_valid  in  1  in_byte is valid
- in_last  in  1  final byte of the genome; qualified by in_valid
- in_ready  out  1  block can accept a byte this cycle
- pkt_data  out  PKT_W  packet; byte k occupies [8k+7:8k], with byte 0 the earliest
- pkt_bytes  out  CNT_W  number of valid bytes, 1..BYTES_PER_PKT
- pkt_last  out  1  packet holds the final genome byte
- pkt_index  out  IDX_W  packet sequence number within the current genome
- pkt_valid  out  1  packet outputs are valid
- pkt_ready  in  1  Extender accepts the packet

Behaviour:
- One clock domain, clk. Reset is asynchronous and active-low on rst_n.
- State held: two buffers buf[0..1], each PKT_W wide with a count and a last flag; full[1:0]; wr_sel and rd_sel (1 bit each); wr_cnt (CNT_W).
- Reset values:
  - full = 0, wr_sel = rd_sel = 0, wr_cnt = 0, buffers = 0.
  - pkt_valid = 0, pkt_data = 0, pkt_bytes = 0, pkt_last = 0, pkt_index = 0.
  - in_ready = 1 once reset deasserts.
- in_ready = !full[wr_sel], combinational from registers only. It never depends on in_valid or pkt_ready.
- Input accept occurs when in_valid && in_ready:
  - Write buf[wr_sel] byte wr_cnt; wr_cnt increments.
  - When wr_cnt == 0 on accept, the buffer's remaining bytes are cleared in the same cycle.
  - If wr_cnt == BYTES_PER_PKT-1 or in_last: set full[wr_sel], store count = wr_cnt+1 and last = in_last, toggle wr_sel, reset wr_cnt to 0.
- Output side:
  - pkt_valid = full[rd_sel]; pkt_data, pkt_bytes and pkt_last come from buf[rd_sel].
  - Bytes at or above pkt_bytes are always 0.
- Latency: pkt_valid asserts in the cycle after the accept that completes the packet.
- Output handshake occurs when pkt_valid && pkt_ready:
  - Clear full[rd_sel] and toggle rd_sel.
  - pkt_index increments. If pkt_last, it returns to 0 instead.
  - pkt_index wraps modulo 2^IDX_W.
- AXI-style stability: while pkt_valid && !pkt_ready, all pkt_* outputs hold.
- Simultaneous fill of one buffer and drain of the other in the same cycle is legal. Both updates apply.
- Both buffers full: in_ready = 0. It returns to 1 the cycle after the next output handshake.
- Throughput: sustained 1 byte/cycle, provided pkt_ready is asserted at least once every BYTES_PER_PKT cycles.
- in_last followed immediately by new bytes is legal. The next genome starts in a fresh packet with index 0.
- Reset mid-operation discards all buffered data. No partial packet is emitted.

Decomposition:
- proj_pkg additions:
  - FM_PKT_W = EXTENDER_MEM_LEN.
  - FM_PKT_CNT_W = $clog2(FM_EXTENDER_BYTES_READ_COUNT+1).
  - FM_PKT_IDX_W = 16.
  - typedef fm_pkt_t: a struct holding data, bytes, last and index, for reuse by the Extender receive side.
- One sub-module, fm_pkt_buf: a single packet buffer with write-byte, clear-on-first and full/count/last registers.
  - fm_packet_tx instantiates two fm_pkt_buf instances and holds the pointers and index logic.

Test Plan:
- Basic packing: stream bytes 0x00..0x0F back-to-back with pkt_ready=1 -> one cycle after the 16th accept, pkt_valid=1, pkt_data=128'h0F0E0D0C0B0A09080706050403020100, pkt_bytes=16, pkt_last=0, pkt_index=0.
- Sustained throughput: 64 continuous bytes with pkt_ready=1 -> in_ready never drops; 4 packets with pkt_index 0,1,2,3.
- Backpressure: pkt_ready=0 while offering 40 bytes -> exactly 32 accepted, then in_ready=0 and pkt_data holds stable. Raise pkt_ready for 1 cycle -> in_ready=1 the next cycle and byte 33 is accepted.
- Partial last packet: bytes 0xA1..0xA5 with in_last on 0xA5 -> pkt_bytes=5, pkt_last=1, pkt_data[127:40]=0, pkt_data[39:0]=40'hA5A4A3A2A1. The next genome's first packet has pkt_index=0 and all upper bytes zero.
- Edge case, last on a full boundary: in_last on the 16th byte -> one packet with pkt_bytes=16 and pkt_last=1; no extra empty packet is emitted.
- Reset mid-operation: assert rst_n=0 after 7 bytes with one packet pending -> pkt_valid=0, in_ready=1, pkt_index=0 immediately, without waiting for a clock edge. A following 16-byte stream produces a clean packet with index 0.

Source files
------------

// File: rtl/fm_packet_tx_pkg.sv
// Shared constants and types for the FM-to-Extender memory-packet interface.
// Imported by the packet buffer, the transmit top and the Extender receive side.
package fm_packet_tx_pkg;

    localparam int FM_EXTENDER_BYTES_READ_COUNT = 16;
    localparam int GENOME_BTYE                  = 8;
    localparam int EXTENDER_MEM_LEN             = FM_EXTENDER_BYTES_READ_COUNT * GENOME_BTYE;
    localparam int FM_BUFFER_COUNT              = 2;

    localparam int FM_PKT_W     = EXTENDER_MEM_LEN;
    localparam int FM_PKT_CNT_W = $clog2(FM_EXTENDER_BYTES_READ_COUNT + 1);
    localparam int FM_PKT_IDX_W = 16;

    // One packet as seen by the Extender.
    typedef struct packed {
        logic [FM_PKT_W-1:0]     data;
        logic [FM_PKT_CNT_W-1:0] bytes;
        logic                    last;
        logic [FM_PKT_IDX_W-1:0] index;
    } fm_pkt_t;

endpackage

// File: rtl/fm_pkt_buf.sv
// Single packet buffer: byte-addressed write, clear of the whole buffer on the
// first byte of a packet, and full/count/last registers.
// Ports:
//   wr_en/wr_pos/wr_byte  write wr_byte into byte slot wr_pos
//   close_en/close_last   packet complete on this write; latch count and last
//   drain_en              packet consumed downstream; release the buffer
//   data/cnt/last/full    registered buffer contents
module fm_pkt_buf
    import fm_packet_tx_pkg::*;
#(
    parameter int BYTES_PER_PKT = FM_EXTENDER_BYTES_READ_COUNT,
    parameter int BYTE_W        = GENOME_BTYE,
    parameter int CNT_W         = $clog2(BYTES_PER_PKT + 1)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en,
    input  logic [CNT_W-1:0]                wr_pos,
    input  logic [BYTE_W-1:0]               wr_byte,
    input  logic                            close_en,
    input  logic                            close_last,
    input  logic                            drain_en,
    output logic [BYTES_PER_PKT*BYTE_W-1:0] data,
    output logic [CNT_W-1:0]                cnt,
    output logic                            last,
    output logic                            full
);

    localparam int PKT_W = BYTES_PER_PKT * BYTE_W;

    logic [PKT_W-1:0] data_q, data_d;
    logic [CNT_W-1:0] cnt_q,  cnt_d;
    logic             last_q, last_d;
    logic             full_q, full_d;

    always_comb begin
        // NOTE: every comb output gets a default first, otherwise a latch is inferred.
        data_d = data_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        full_d = full_q;

        if (wr_en) begin
            // Wiping on the first byte keeps every slot past the count at zero.
            if (wr_pos == '0) begin
                data_d = '0;
            end
            for (int k = 0; k < BYTES_PER_PKT; k++) begin
                if (wr_pos == CNT_W'(k)) begin
                    data_d[k*BYTE_W +: BYTE_W] = wr_byte;
                end
            end
        end

        if (close_en) begin
            cnt_d  = wr_pos + CNT_W'(1);
            last_d = close_last;
            full_d = 1'b1;
        end else if (drain_en) begin
            full_d = 1'b0;
        end
    end

    // NOTE: the buffer storage is reset too, because its contents are visible
    // on pkt_data and must read as zero straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
            full_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment only.
            data_q <= data_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
            full_q <= full_d;
        end
    end

    assign data = data_q;
    assign cnt  = cnt_q;
    assign last = last_q;
    assign full = full_q;

endmodule

// File: rtl/fm_packet_tx.sv
// Transmit side of the FM-to-Extender memory-packet interface. Packs a genome
// byte stream into fixed-size packets using two ping-pong buffers, so one packet
// fills while the other drains over a valid/ready handshake.
// Ports:
//   in_byte/in_valid/in_last/in_ready   byte stream input (one byte per cycle)
//   pkt_data/pkt_bytes/pkt_last/pkt_index/pkt_valid/pkt_ready   packet output
module fm_packet_tx
    import fm_packet_tx_pkg::*;
#(
    parameter int BYTES_PER_PKT = FM_EXTENDER_BYTES_READ_COUNT,
    parameter int BYTE_W        = GENOME_BTYE,
    parameter int IDX_W         = FM_PKT_IDX_W,
    localparam int PKT_W        = BYTES_PER_PKT * BYTE_W,
    localparam int CNT_W        = $clog2(BYTES_PER_PKT + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [BYTE_W-1:0] in_byte,
    input  logic              in_valid,
    input  logic              in_last,
    output logic              in_ready,
    output logic [PKT_W-1:0]  pkt_data,
    output logic [CNT_W-1:0]  pkt_bytes,
    output logic              pkt_last,
    output logic [IDX_W-1:0]  pkt_index,
    output logic              pkt_valid,
    input  logic              pkt_ready
);

    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
    logic [IDX_W-1:0] idx_q,    idx_d;

    logic [PKT_W-1:0] pb_data [FM_BUFFER_COUNT];
    logic [CNT_W-1:0] pb_cnt  [FM_BUFFER_COUNT];
    logic             pb_last [FM_BUFFER_COUNT];
    logic [FM_BUFFER_COUNT-1:0] full;

    logic accept;
    logic close;
    logic pop;

    // Handshakes; in_ready depends on registers only.
    assign in_ready = !full[wr_sel_q];
    assign accept   = in_valid && in_ready;
    assign close    = accept && ((wr_cnt_q == CNT_W'(BYTES_PER_PKT - 1)) || in_last);
    assign pop      = pkt_valid && pkt_ready;

    for (genvar g = 0; g < FM_BUFFER_COUNT; g++) begin : g_buf
        fm_pkt_buf #(
            .BYTES_PER_PKT (BYTES_PER_PKT),
            .BYTE_W        (BYTE_W),
            .CNT_W         (CNT_W)
        ) u_buf (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en      (accept && (wr_sel_q == 1'(g))),
            .wr_pos     (wr_cnt_q),
            .wr_byte    (in_byte),
            .close_en   (close && (wr_sel_q == 1'(g))),
            .close_last (in_last),
            .drain_en   (pop && (rd_sel_q == 1'(g))),
            .data       (pb_data[g]),
            .cnt        (pb_cnt[g]),
            .last       (pb_last[g]),
            .full       (full[g])
        );
    end

    // Pointer and index next-state logic.
    always_comb begin
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wr_cnt_d = wr_cnt_q;
        idx_d    = idx_q;

        if (close) begin
            wr_sel_d = !wr_sel_q;
            wr_cnt_d = '0;
        end else if (accept) begin
            wr_cnt_d = wr_cnt_q + CNT_W'(1);
        end

        if (pop) begin
            rd_sel_d = !rd_sel_q;
            // A genome's final packet restarts numbering for the next genome.
            idx_d    = pb_last[rd_sel_q] ? '0 : idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_cnt_q <= '0;
            idx_q    <= '0;
        end else begin
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_cnt_q <= wr_cnt_d;
            idx_q    <= idx_d;
        end
    end

    // Output side reads straight from the buffer selected by rd_sel.
    assign pkt_valid = full[rd_sel_q];
    assign pkt_data  = pb_data[rd_sel_q];
    assign pkt_bytes = pb_cnt[rd_sel_q];
    assign pkt_last  = pb_last[rd_sel_q];
    assign pkt_index = idx_q;

endmodule
